// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   state_t   : control FSM states (IDLE, RUN, DONE), 2-bit encoding
//   WIDTH_MIN : smallest operand width the serial datapath supports
// ---------------------------------------------------------------------------
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 2;

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// Combinational one-bit subtractor cell: d = x - y - bi.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   // A borrow is produced when y exceeds x outright, or when x == y and a
   // borrow is already pending from the lower bit.
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full_subtractor cell plus a borrow flop replaces a ripple chain.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   start : request, only honoured in IDLE
//   a, b  : minuend / subtrahend, captured on the accepted start edge
//   bin   : borrow in, captured on the accepted start edge
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse marking a valid result
//   diff  : difference, held until the next accepted start
//   bout  : final borrow out (unsigned a < b + bin)
//   ovf   : signed two's-complement overflow
//   zero  : diff == 0 for a completed result
// ---------------------------------------------------------------------------
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   aSh_q, aSh_d;
   logic [WIDTH-1:0]   bSh_q, bSh_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               borrow_q, borrow_d;
   logic               bout_q, bout_d;
   logic               ovf_q, ovf_d;
   logic               valid_q, valid_d;
   logic               bitD;
   logic               bitBo;

   // The single arithmetic cell, fed from the LSBs of the shift registers.
   full_subtractor uCell (
      .x  (aSh_q[0]),
      .y  (bSh_q[0]),
      .bi (borrow_q),
      .d  (bitD),
      .bo (bitBo)
   );

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         aSh_q    <= '0;
         bSh_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         aSh_q    <= aSh_d;
         bSh_q    <= bSh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
      end
   end

   // Next-state logic. IDLE captures operands on start, RUN consumes one bit
   // per edge shifting the result in from the top, and the final bit edge
   // latches borrow-out and overflow (borrow into MSB xor borrow out of MSB).
   always_comb begin
      state_d  = state_q;
      aSh_d    = aSh_q;
      bSh_d    = bSh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      valid_d  = valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               aSh_d    = a;
               bSh_d    = b;
               borrow_d = bin;
               cnt_d    = '0;
               diff_d   = '0;
               bout_d   = 1'b0;
               ovf_d    = 1'b0;
               valid_d  = 1'b0;
            end
         end
         RUN: begin
            diff_d   = {bitD, diff_q[WIDTH-1:1]};
            aSh_d    = aSh_q >> 1;
            bSh_d    = bSh_q >> 1;
            borrow_d = bitBo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               bout_d  = bitBo;
               ovf_d   = borrow_q ^ bitBo;
               valid_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // zero is qualified by valid_q so a cleared or partially built diff never
   // reads as a zero result (including straight out of reset).
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = valid_q && (diff_q == '0);

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results
// come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;
   logic         zero;

   int checkCount = 0;
   int failCount  = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf),
      .zero  (zero)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Reference model: result of a - b - bin from integer arithmetic.
   function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ibin, output logic [W-1:0] expD,
                                 output logic expBo, output logic expOv,
                                 output logic expZ);
      int ua;
      int ub;
      int sa;
      int sb;
      int r;
      int sr;
      ua    = int'(ia);
      ub    = int'(ib);
      sa    = int'($signed(ia));
      sb    = int'($signed(ib));
      r     = ua - ub - int'(ibin);
      sr    = sa - sb - int'(ibin);
      expD  = W'(r);
      expBo = (ua < ub + int'(ibin));
      expOv = (sr > 127) || (sr < -128);
      expZ  = (expD == '0);
   endfunction

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] expv);
      checkCount++;
      assert (obs === expv)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Runs one operation from a start pulse. Inputs are scrambled while busy;
   // glitchAt >= 0 re-raises start with different operands at that cycle.
   task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic ibin, input int glitchAt,
                                input string tag);
      logic [W-1:0] expD;
      logic         expBo;
      logic         expOv;
      logic         expZ;
      int           doneAt;
      int           busyN;
      int           doneN;
      model(ia, ib, ibin, expD, expBo, expOv, expZ);
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      doneAt = -1; busyN = 0; doneN = 0;
      for (int k = 0; k < W + 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         a     = W'($urandom);
         b     = W'($urandom);
         bin   = 1'($urandom);
         if (k == glitchAt) begin
            start = 1'b1;
            a     = ~ia;
            b     = ia;
            bin   = ~ibin;
         end
         if (busy) busyN++;
         if (done) begin
            doneN++;
            if (doneAt < 0) begin
               doneAt = k;
               checkOutput({tag, ".diff"}, 64'(diff), 64'(expD));
               checkOutput({tag, ".bout"}, 64'(bout), 64'(expBo));
               checkOutput({tag, ".ovf"},  64'(ovf),  64'(expOv));
               checkOutput({tag, ".zero"}, 64'(zero), 64'(expZ));
            end
         end
      end
      checkOutput({tag, ".latency"}, 64'(doneAt), 64'(W));
      checkOutput({tag, ".donePulses"}, 64'(doneN), 64'd1);
      checkOutput({tag, ".busyCycles"}, 64'(busyN), 64'(W + 1));
      checkOutput({tag, ".diffHeld"}, 64'(diff), 64'(expD));
      checkOutput({tag, ".boutHeld"}, 64'(bout), 64'(expBo));
      checkOutput({tag, ".zeroHeld"}, 64'(zero), 64'(expZ));
   endtask

   initial begin
      int prevDone;
      int pulses;
      int doneN;

      reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst.busy", 64'(busy), 64'd0);
      checkOutput("rst.done", 64'(done), 64'd0);
      checkOutput("rst.diff", 64'(diff), 64'd0);
      checkOutput("rst.bout", 64'(bout), 64'd0);
      checkOutput("rst.ovf",  64'(ovf),  64'd0);
      checkOutput("rst.zero", 64'(zero), 64'd0);
      reset = 1'b0;

      $display("[TB] directed operations");
      applyStimulus(8'd200, 8'd55, 1'b0, -1, "d200m55");
      applyStimulus(8'd5,   8'd10, 1'b0, -1, "d5m10");
      applyStimulus(8'h80,  8'h01, 1'b0, -1, "d80m01");
      applyStimulus(8'h3C,  8'h3B, 1'b1, -1, "d3Cm3Bb");
      applyStimulus(8'h00,  8'h00, 1'b1, -1, "d00m00b");

      $display("[TB] start while busy");
      applyStimulus(8'd200, 8'd55, 1'b0, 3, "glitch");

      $display("[TB] reset mid-operation");
      @(negedge clk);
      a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("midRst.busy", 64'(busy), 64'd0);
      checkOutput("midRst.done", 64'(done), 64'd0);
      checkOutput("midRst.diff", 64'(diff), 64'd0);
      checkOutput("midRst.bout", 64'(bout), 64'd0);
      checkOutput("midRst.ovf",  64'(ovf),  64'd0);
      checkOutput("midRst.zero", 64'(zero), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      doneN = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) doneN++;
      end
      checkOutput("midRst.noDone", 64'(doneN), 64'd0);
      applyStimulus(8'd9, 8'd4, 1'b0, -1, "afterRst");

      $display("[TB] start held high");
      @(negedge clk);
      a = 8'd100; b = 8'd1; bin = 1'b0; start = 1'b1;
      prevDone = -1; pulses = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            checkOutput("held.diff", 64'(diff), 64'd99);
            if (prevDone >= 0)
               checkOutput("held.period", 64'(k - prevDone), 64'(W + 2));
            else
               checkOutput("held.first", 64'(k), 64'(W));
            prevDone = k;
         end
      end
      start = 1'b0;
      checkOutput("held.pulses", 64'(pulses), 64'd3);
      repeat (12) @(negedge clk);

      $display("[TB] random operations");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom), -1, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checkCount, failCount);
      $finish;
   end

endmodule
